// File: rtl/core_pkg.sv
// core_pkg: result-source codes, load funct3 encodings and helpers shared by the writeback stage.
package core_pkg;
  localparam logic [1:0] RESULT_ALU = 2'b00, RESULT_MEM = 2'b01, RESULT_PC4 = 2'b10, RESULT_IMM = 2'b11;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LD = 3'b011;
  localparam logic [2:0] LBU = 3'b100, LHU = 3'b101, LWU = 3'b110;
  function automatic int off_w(input int xlen);
    return xlen == 64 ? 3 : 2;
  endfunction
endpackage

// File: rtl/load_formatter.sv
// load_formatter: extracts and extends load data at a byte offset and flags misaligned or illegal loads.
module load_formatter import core_pkg::*; #(
  parameter int XLEN = 32,
  localparam int OW = off_w(XLEN)
) (
  input  logic [2:0]      funct3,
  input  logic [OW-1:0]   off,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] data,
  output logic            misalign
);
  logic [XLEN-1:0] sh;
  assign sh = raw >> {off, 3'b000};
  // Illegal encodings fall through with the raw word and the misaligned flag set.
  always_comb begin
    data = raw;
    misalign = 1'b1;
    case (funct3)
      LB:  begin data = XLEN'($signed(sh[7:0])); misalign = 1'b0; end
      LBU: begin data = XLEN'(sh[7:0]); misalign = 1'b0; end
      LH:  begin data = XLEN'($signed(sh[15:0])); misalign = off[0]; end
      LHU: begin data = XLEN'(sh[15:0]); misalign = off[0]; end
      LW:  begin data = XLEN'($signed(sh[31:0])); misalign = |off[1:0]; end
      LWU: if (XLEN == 64) begin data = XLEN'(sh[31:0]); misalign = |off[1:0]; end
      LD:  if (XLEN == 64) begin data = sh; misalign = |off; end
      default: ;
    endcase
  end
endmodule

// File: rtl/writeback_stage_p.sv
// writeback_stage_p: MEM/WB pipeline register with load formatting, result select,
// register-file write gating and a retired-instruction counter.
module writeback_stage_p import core_pkg::*; #(
  parameter int XLEN = 32,
  parameter int RADDR_W = 5,
  parameter int RET_CNT_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ValidM,
  input  logic                 RegWriteM,
  input  logic [1:0]           ResultSrcM,
  input  logic [2:0]           LoadFunct3M,
  input  logic [RADDR_W-1:0]   RdM,
  input  logic [XLEN-1:0]      ALU_ResultM,
  input  logic [XLEN-1:0]      ReadDataM,
  input  logic [XLEN-1:0]      PCPlus4M,
  input  logic [XLEN-1:0]      ImmExtM,
  input  logic                 StallW,
  input  logic                 FlushW,
  output logic                 ValidW,
  output logic                 RegWriteW,
  output logic [RADDR_W-1:0]   RdW,
  output logic [XLEN-1:0]      ResultW,
  output logic                 MisalignW,
  output logic [RET_CNT_W-1:0] InstRetW
);
  localparam int OW = off_w(XLEN);
  logic                valid_q, regwrite_q, mis;
  logic [1:0]          src_q;
  logic [2:0]          f3_q;
  logic [RADDR_W-1:0]  rd_q;
  logic [XLEN-1:0]     alu_q, rdata_q, pc4_q, imm_q, load_data;
  load_formatter #(.XLEN(XLEN)) u_fmt (
    .funct3(f3_q), .off(alu_q[OW-1:0]), .raw(rdata_q), .data(load_data), .misalign(mis)
  );
  assign ValidW = valid_q;
  assign RdW = rd_q;
  assign MisalignW = valid_q & (src_q == RESULT_MEM) & mis;
  assign RegWriteW = valid_q & regwrite_q & (rd_q != '0) & ~MisalignW;
  assign ResultW = src_q == RESULT_ALU ? alu_q : src_q == RESULT_MEM ? load_data :
                   src_q == RESULT_PC4 ? pc4_q : imm_q;
  // A flush only kills the incoming slot; the departing instruction still retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {valid_q, regwrite_q, src_q, f3_q, rd_q} <= '0;
      {alu_q, rdata_q, pc4_q, imm_q} <= '0;
      InstRetW <= '0;
    end else begin
      if (FlushW) valid_q <= 1'b0;
      else if (!StallW) begin
        {valid_q, regwrite_q, src_q, f3_q, rd_q} <= {ValidM, RegWriteM, ResultSrcM, LoadFunct3M, RdM};
        {alu_q, rdata_q, pc4_q, imm_q} <= {ALU_ResultM, ReadDataM, PCPlus4M, ImmExtM};
      end
      if (valid_q && (!StallW || FlushW) && !MisalignW) InstRetW <= InstRetW + RET_CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_writeback_stage_p.sv
// tb_writeback_stage_p: scoreboard bench driving a 32-bit and a 64-bit (4-bit counter) instance.
module tb_writeback_stage_p;
  logic clk = 0, rst = 0;
  logic valid_m = 0, regwrite_m = 0, stall = 0, flush = 0;
  logic [1:0] src_m = 0;
  logic [2:0] f3_m = 0;
  logic [4:0] rd_m = 0;
  logic [63:0] alu_m = 0, rdata_m = 0, pc4_m = 0, imm_m = 0;
  logic v32, rw32, mis32, v64, rw64, mis64;
  logic [4:0] rd32, rd64;
  logic [31:0] res32;
  logic [63:0] res64, ret32;
  logic [3:0] ret64;
  int n_tests = 0, n_fail = 0, ret_exp = 0;
  bit pend = 0;

  typedef struct {
    bit w64; logic v, rw, mis, cr; logic [4:0] rd; logic [63:0] res; string tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  writeback_stage_p u32 (
    .clk(clk), .rst(rst), .ValidM(valid_m), .RegWriteM(regwrite_m), .ResultSrcM(src_m),
    .LoadFunct3M(f3_m), .RdM(rd_m), .ALU_ResultM(alu_m[31:0]), .ReadDataM(rdata_m[31:0]),
    .PCPlus4M(pc4_m[31:0]), .ImmExtM(imm_m[31:0]), .StallW(stall), .FlushW(flush),
    .ValidW(v32), .RegWriteW(rw32), .RdW(rd32), .ResultW(res32), .MisalignW(mis32), .InstRetW(ret32)
  );
  writeback_stage_p #(.XLEN(64), .RET_CNT_W(4)) u64 (
    .clk(clk), .rst(rst), .ValidM(valid_m), .RegWriteM(regwrite_m), .ResultSrcM(src_m),
    .LoadFunct3M(f3_m), .RdM(rd_m), .ALU_ResultM(alu_m), .ReadDataM(rdata_m),
    .PCPlus4M(pc4_m), .ImmExtM(imm_m), .StallW(stall), .FlushW(flush),
    .ValidW(v64), .RegWriteW(rw64), .RdW(rd64), .ResultW(res64), .MisalignW(mis64), .InstRetW(ret64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic op(input string tag, input bit w64, input logic v, rw, input logic [1:0] src,
                    input logic [2:0] f3, input logic [4:0] rd, input logic [63:0] alu, rdata, pc4, imm,
                    input logic [63:0] res, input logic erw, emis, cr);
    exp_t e;
    {valid_m, regwrite_m, src_m, f3_m, rd_m} = {v, rw, src, f3, rd};
    {alu_m, rdata_m, pc4_m, imm_m} = {alu, rdata, pc4, imm};
    sb.push_back('{w64, v, erw, emis, cr, rd, res, tag});
    @(posedge clk); #1;
    e = sb.pop_front();
    ret_exp += int'(pend);
    check({e.tag, "_valid"}, e.w64 ? v64 : v32, e.v);
    check({e.tag, "_regwrite"}, e.w64 ? rw64 : rw32, e.rw);
    check({e.tag, "_rd"}, e.w64 ? rd64 : rd32, e.rd);
    check({e.tag, "_misalign"}, e.w64 ? mis64 : mis32, e.mis);
    if (e.cr) check({e.tag, "_result"}, e.w64 ? res64 : {32'b0, res32}, e.w64 ? e.res : {32'b0, e.res[31:0]});
    check({e.tag, "_instret"}, e.w64 ? {60'b0, ret64} : ret32, e.w64 ? 64'(ret_exp % 16) : 64'(ret_exp));
    pend = e.v && !e.mis;
  endtask

  task automatic alu_op(input string tag, input bit w64, input logic [4:0] rd, input logic [63:0] val);
    op(tag, w64, 1, 1, 2'b00, 3'b000, rd, val, 0, 0, 0, val, rd != 0, 0, 1);
  endtask

  task automatic ld_op(input string tag, input bit w64, input logic [2:0] f3, input logic [63:0] off,
                       rdata, res, input logic emis, cr);
    op(tag, w64, 1, 1, 2'b01, f3, 5'd10, off, rdata, 0, 0, res, !emis, emis, cr);
  endtask

  initial begin
    #3;
    check("rst_valid", v32, 0); check("rst_regwrite", rw32, 0); check("rst_rd", rd32, 0);
    check("rst_result", res32, 0); check("rst_misalign", mis32, 0); check("rst_instret", ret32, 0);
    rst = 1;
    alu_op("alu", 0, 5, 64'h1234);
    ld_op("lb3", 0, 3'b000, 3, 64'h80FF7F01, 64'hFFFFFF80, 0, 1);
    ld_op("lbu3", 0, 3'b100, 3, 64'h80FF7F01, 64'h00000080, 0, 1);
    ld_op("lh2", 0, 3'b001, 2, 64'h80FF7F01, 64'hFFFF80FF, 0, 1);
    ld_op("lhu0", 0, 3'b101, 0, 64'h80FF7F01, 64'h00007F01, 0, 1);
    ld_op("lw0", 0, 3'b010, 0, 64'h80FF7F01, 64'h80FF7F01, 0, 1);
    ld_op("lh1_mis", 0, 3'b001, 1, 64'h80FF7F01, 0, 1, 0);
    ld_op("lw2_mis", 0, 3'b010, 2, 64'h80FF7F01, 0, 1, 0);
    ld_op("ld32_ill", 0, 3'b011, 0, 64'h80FF7F01, 64'h80FF7F01, 1, 1);
    alu_op("x0", 0, 0, 64'hDEAD);
    op("pc4", 0, 1, 1, 2'b10, 0, 6, 0, 0, 64'h104, 0, 64'h104, 1, 0, 1);
    op("imm", 0, 1, 1, 2'b11, 0, 7, 0, 0, 0, 64'hABCDE000, 64'hABCDE000, 1, 0, 1);
    alu_op("pre_stall", 0, 8, 64'h55);
    stall = 1;
    {valid_m, rd_m, alu_m} = {1'b1, 5'd9, 64'h999};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_result", res32, 64'h55); check("stall_rd", rd32, 8);
      check("stall_instret", ret32, 64'(ret_exp));
    end
    stall = 0;
    op("release", 0, 0, 0, 2'b00, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    alu_op("pre_flush", 0, 3, 64'h33);
    {stall, flush} = 2'b11;
    @(posedge clk); #1;
    ret_exp += int'(pend); pend = 0;
    check("stallflush_valid", v32, 0); check("stallflush_instret", ret32, 64'(ret_exp));
    {stall, flush} = 2'b00;
    alu_op("pre_rst", 0, 4, 64'h77);
    #2 rst = 0;
    #1;
    check("arst_valid", v32, 0); check("arst_regwrite", rw32, 0); check("arst_rd", rd32, 0);
    check("arst_result", res32, 0); check("arst_instret", ret32, 0); check("arst_ret64", ret64, 0);
    rst = 1; ret_exp = 0; pend = 0;
    ld_op("lwu4", 1, 3'b110, 4, 64'hF0000000_00000000, 64'h00000000_F0000000, 0, 1);
    ld_op("ld0", 1, 3'b011, 0, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF, 0, 1);
    ld_op("lw4", 1, 3'b010, 4, 64'h80000000_00000000, 64'hFFFFFFFF_80000000, 0, 1);
    ld_op("ld4_mis", 1, 3'b011, 4, 64'h01234567_89ABCDEF, 0, 1, 0);
    for (int i = 0; i < 20 && ret_exp != 16; i++) alu_op("wrap", 1, 1, 64'(i));
    check("wrap_zero", ret64, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_stage_p.md
Name: writeback_stage_p

Overview:
- Parametrised MEM/WB pipeline register plus writeback stage for the pipelined RISC-V core.
- Registers memory-stage results and formats load data: byte/half/word, plus doubleword when XLEN=64, with sign or zero extension.
- Selects among four result sources and drives the register-file write port and the forwarding path.
- Adds stall/flush handling, misaligned-load detection and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64 only.
- RADDR_W, 5, register address width.
- RET_CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ValidM  in  1  memory-stage slot holds a real instruction.
- RegWriteM  in  1  instruction writes rd.
- ResultSrcM  in  2  00 ALU, 01 load data, 10 PC+4, 11 ImmExt (LUI).
- LoadFunct3M  in  3  load funct3; used only when ResultSrcM=01.
- RdM  in  RADDR_W  destination register.
- ALU_ResultM  in  XLEN  ALU result; low bits give the load byte offset.
- ReadDataM  in  XLEN  raw aligned memory word.
- PCPlus4M  in  XLEN  PC+4.
- ImmExtM  in  XLEN  extended immediate.
- StallW  in  1  hold the WB register.
- FlushW  in  1  insert a bubble.
- ValidW  out  1  WB slot holds a real instruction.
- RegWriteW  out  1  register-file write enable.
- RdW  out  RADDR_W  register-file write address.
- ResultW  out  XLEN  write data; also the forwarding source.
- MisalignW  out  1  misaligned load currently in WB.
- InstRetW  out  RET_CNT_W  retired-instruction count.

Behaviour:
- Reset (rst=0, asynchronous): all pipeline registers and InstRetW clear to 0.
  - Resulting outputs: ValidW=0, RegWriteW=0, RdW=0, ResultW=0, MisalignW=0.
- Latency: one cycle from M inputs to W outputs.
  - W outputs are combinational from registered state only; no input-to-output combinational path.
- Register update, per rising edge, in priority order:
  - FlushW=1: valid_q<=0; other fields don't-care, held. Flush wins over stall.
  - else StallW=1: all fields hold.
  - else: capture all M inputs.
- Offset: off = ALU_Result_q[OW-1:0], where OW=2 for XLEN=32 and OW=3 for XLEN=64.
- Load formatting, by funct3_q:
  - 000 LB, 100 LBU: byte at off, sign- or zero-extended to XLEN.
  - 001 LH, 101 LHU: halfword at off.
  - 010 LW: word at off, sign-extended.
  - 110 LWU, 011 LD: XLEN=64 only; LWU zero-extends.
  - Any other funct3 (including LWU/LD when XLEN=32): the result is the raw word and the load is flagged misaligned.
- Misalignment rules:
  - Halfword load with off[0]=1.
  - Word load with off[1:0]!=0.
  - LD with off!=0.
  - Illegal funct3.
- MisalignW = valid_q & (ResultSrc_q==01) & misaligned.
- ResultW selection:
  - 00: ALU_Result_q.
  - 01: formatted load data.
  - 10: PCPlus4_q.
  - 11: ImmExt_q.
- RegWriteW = valid_q & RegWrite_q & (Rd_q!=0) & ~MisalignW. Writes to x0 are always suppressed.
- ValidW = valid_q; RdW = Rd_q.
- Retire counter:
  - InstRetW increments by 1 on an edge where valid_q=1, StallW=0 and MisalignW=0.
  - A stalled instruction counts once, on the edge it leaves.
  - The counter wraps from all-ones to 0.
  - Flush does not decrement the count or suppress the current retire.
  - Reset mid-count clears the counter immediately.
- Simultaneous StallW=1 and FlushW=1: the bubble is inserted; the departing valid instruction retires if not misaligned.

Decomposition:
- Shared package core_pkg holds:
  - RESULT_ALU/MEM/PC4/IMM 2-bit codes.
  - Load funct3 constants LB, LH, LW, LD, LBU, LHU, LWU.
- One sub-module, load_formatter: combinational; inputs funct3, offset and raw data; outputs formatted data and the misaligned flag. Parametrised by XLEN.
- The pipeline register, result mux and counter stay in the top module.

Test Plan:
- Reset, then an ALU op, XLEN=32: ValidM=1, RegWriteM=1, RdM=5, ResultSrcM=00, ALU_ResultM=0x1234 -> next cycle ResultW=0x1234, RegWriteW=1, RdW=5; InstRetW=1 one edge later.
- Loads with ReadDataM=0x80FF7F01, ResultSrcM=01:
  - LB off=3 -> ResultW=0xFFFFFF80.
  - LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=0 -> 0x00007F01.
  - In each case MisalignW=0.
- Misaligned loads: LH off=1 and LW off=2 -> MisalignW=1, RegWriteW=0, InstRetW unchanged.
- Write to x0 and other sources:
  - RdM=0 with RegWriteM=1 -> RegWriteW=0, InstRetW increments.
  - ResultSrcM=10 with PCPlus4M=0x104 -> ResultW=0x104.
  - ResultSrcM=11 with ImmExtM=0xABCDE000 -> ResultW=0xABCDE000.
- Stall/flush:
  - StallW=1 for 3 cycles -> W outputs frozen, InstRetW frozen; a single increment after release.
  - StallW=1 with FlushW=1 -> ValidW=0 next cycle.
  - rst asserted mid-stream -> all outputs 0 without a clock edge.
- XLEN=64, RET_CNT_W=4:
  - LWU off=4 with ReadDataM=0xF0000000_00000000 -> ResultW=0x00000000_F0000000.
  - LD off=0 -> raw data.
  - 16 retires -> InstRetW wraps to 0.
